// File: rtl/rv_mon_pkg.sv
// Shared types for the RV32i store-bus monitor: FSM states, store sizes,
// failure causes and the packed log entry layout.
package rv_mon_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        PASS    = 3'd2,
        FAIL    = 3'd3,
        TIMEOUT = 3'd4
    } mon_state_e;

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_B    = 2'b01;
    localparam logic [1:0] SZ_H    = 2'b10;
    localparam logic [1:0] SZ_W    = 2'b11;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_BAD      = 2'b01,
        FC_MISALIGN = 2'b10,
        FC_TIMEOUT  = 2'b11
    } fail_cause_e;

    localparam int unsigned ADR_W       = 32;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned LOG_ENTRY_W = 2 + ADR_W + DATA_W;

    typedef struct packed {
        logic [1:0]        size;
        logic [ADR_W-1:0]  adr;
        logic [DATA_W-1:0] data;
    } log_entry_t;

    // Zero-extend the live lanes of an LSB-aligned store.
    function automatic logic [DATA_W-1:0] mask_data(input logic [1:0] size,
                                                    input logic [DATA_W-1:0] data);
        case (size)
            SZ_B:    return {24'd0, data[7:0]};
            SZ_H:    return {16'd0, data[15:0]};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an extra pointer bit to separate full from empty.
// A pop frees the slot a same-cycle push needs, so push+pop when full both succeed.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/store_monitor.sv
// Passive observer of the core store bus: decides pass/fail, logs stores
// into a FIFO for readback and flags a hung program after a cycle budget.
module store_monitor
    import rv_mon_pkg::*;
#(
    parameter logic [31:0] PASS_ADR    = 32'd100,
    parameter logic [31:0] PASS_DATA   = 32'd25,
    parameter logic [31:0] ALLOW_ADR   = 32'd96,
    parameter int unsigned TIMEOUT_CYC = 20000,
    parameter int unsigned LOG_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    input  logic        LogRdEn,
    output logic [65:0] LogRdData,
    output logic        LogEmpty,
    output logic        LogFull,
    output logic        LogOverflow,
    output logic [15:0] StoreCount,
    output logic        Done,
    output logic        Pass,
    output logic [1:0]  FailCause
);

    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    mon_state_e        state_q;
    mon_state_e        state_d;
    fail_cause_e       cause_q;
    fail_cause_e       cause_d;
    logic [TW-1:0]     tmo_q;
    logic              tmo_hit_c;
    logic              store_c;
    logic              misal_c;
    logic [31:0]       data_m_c;
    log_entry_t        entry_c;

    assign store_c   = (state_q == RUN) && (MemWrite != SZ_NONE);
    assign data_m_c  = mask_data(MemWrite, WriteData);
    assign misal_c   = ((MemWrite == SZ_H) && DataAdr[0]) ||
                       ((MemWrite == SZ_W) && (DataAdr[1:0] != 2'b00));
    assign tmo_hit_c = (tmo_q == TW'(TIMEOUT_CYC - 1));
    assign entry_c   = '{size: MemWrite, adr: DataAdr, data: data_m_c};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a deciding store outranks a coincident timeout.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
                if (store_c && misal_c) begin
                    state_d = FAIL;
                    cause_d = FC_MISALIGN;
                end else if (store_c && (DataAdr == PASS_ADR)) begin
                    if ((MemWrite == SZ_W) && (data_m_c == PASS_DATA)) begin
                        state_d = PASS;
                    end else begin
                        state_d = FAIL;
                        cause_d = FC_BAD;
                    end
                end else if (store_c && (DataAdr != ALLOW_ADR)) begin
                    state_d = FAIL;
                    cause_d = FC_BAD;
                end else if (tmo_hit_c) begin
                    state_d = TIMEOUT;
                    cause_d = FC_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cause_q     <= FC_NONE;
            Done        <= 1'b0;
            Pass        <= 1'b0;
            FailCause   <= 2'b00;
            tmo_q       <= '0;
            StoreCount  <= 16'd0;
            LogOverflow <= 1'b0;
        end else begin
            cause_q   <= cause_d;
            Done      <= (state_d == PASS) || (state_d == FAIL) || (state_d == TIMEOUT);
            Pass      <= (state_d == PASS);
            FailCause <= cause_d;
            if (state_q == RUN) begin
                tmo_q <= tmo_q + TW'(1);
            end
            if (store_c && (StoreCount != 16'hFFFF)) begin
                StoreCount <= StoreCount + 16'd1;
            end
            if (store_c && LogFull && !LogRdEn) begin
                LogOverflow <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (LOG_ENTRY_W),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk   (clk),
        .rst   (rst),
        .push  (store_c),
        .wdata (entry_c),
        .pop   (LogRdEn),
        .rdata (LogRdData),
        .full  (LogFull),
        .empty (LogEmpty)
    );

endmodule

// File: tb/tb_store_monitor.sv
// Directed and randomized checks of store_monitor against a queue-based
// model of the run outcome, store count and store log.
module tb_store_monitor;

    localparam int unsigned TO    = 50;
    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  MemWrite = 2'b00;
    logic [31:0] DataAdr = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic        LogRdEn = 1'b0;
    logic [65:0] LogRdData;
    logic        LogEmpty;
    logic        LogFull;
    logic        LogOverflow;
    logic [15:0] StoreCount;
    logic        Done;
    logic        Pass;
    logic [1:0]  FailCause;

    store_monitor #(
        .PASS_ADR    (32'd100),
        .PASS_DATA   (32'd25),
        .ALLOW_ADR   (32'd96),
        .TIMEOUT_CYC (TO),
        .LOG_DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .MemWrite    (MemWrite),
        .DataAdr     (DataAdr),
        .WriteData   (WriteData),
        .LogRdEn     (LogRdEn),
        .LogRdData   (LogRdData),
        .LogEmpty    (LogEmpty),
        .LogFull     (LogFull),
        .LogOverflow (LogOverflow),
        .StoreCount  (StoreCount),
        .Done        (Done),
        .Pass        (Pass),
        .FailCause   (FailCause)
    );

    always #5 clk = ~clk;

    int npass  = 0;
    int nfail  = 0;
    int ntotal = 0;

    // Reference model: phase 0 = waiting to start, 1 = running, 2 = finished.
    int          m_phase;
    int          m_runcyc;
    int          m_count;
    bit          m_ovf;
    bit          m_done;
    bit          m_pass;
    logic [1:0]  m_cause;
    logic [65:0] m_q[$];

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void finish_run(input bit pass, input logic [1:0] cause);
        m_phase = 2;
        m_done  = 1'b1;
        m_pass  = pass;
        m_cause = cause;
    endfunction

    function automatic void model_edge();
        int        nbytes;
        logic [31:0] masked;
        bit        accepted;
        bit        decided;
        if (rst) begin
            m_phase = 0; m_runcyc = 0; m_count = 0; m_ovf = 0;
            m_done = 0; m_pass = 0; m_cause = 2'b00;
            m_q.delete();
            return;
        end
        nbytes   = (MemWrite == 2'd1) ? 1 : (MemWrite == 2'd2) ? 2 : 4;
        masked   = 32'(longint'(WriteData) & ((longint'(1) << (8 * nbytes)) - 1));
        accepted = (m_phase == 1) && (MemWrite != 2'd0);
        if (LogRdEn && m_q.size() > 0) void'(m_q.pop_front());
        if (accepted) begin
            if (m_q.size() < DEPTH) m_q.push_back({MemWrite, DataAdr, masked});
            else m_ovf = 1;
            if (m_count < 65535) m_count++;
        end
        if (m_phase == 0) begin
            m_phase  = 1;
            m_runcyc = 0;
        end else if (m_phase == 1) begin
            decided = 1;
            if (accepted && (DataAdr % nbytes != 0)) finish_run(0, 2'b10);
            else if (accepted && DataAdr == 100) finish_run(nbytes == 4 && masked == 25, (nbytes == 4 && masked == 25) ? 2'b00 : 2'b01);
            else if (accepted && DataAdr != 96) finish_run(0, 2'b01);
            else decided = 0;
            if (!decided && m_runcyc == TO - 1) finish_run(0, 2'b11);
            m_runcyc++;
        end
    endfunction

    task automatic check_all();
        chk("done", 66'(Done), 66'(m_done));
        chk("pass", 66'(Pass), 66'(m_pass));
        chk("cause", 66'(FailCause), 66'(m_cause));
        chk("count", 66'(StoreCount), 66'(m_count));
        chk("empty", 66'(LogEmpty), 66'(m_q.size() == 0));
        chk("full", 66'(LogFull), 66'(m_q.size() == DEPTH));
        chk("ovf", 66'(LogOverflow), 66'(m_ovf));
        if (m_q.size() > 0) chk("head", LogRdData, m_q[0]);
    endtask

    task automatic cyc(input logic [1:0] mw, input logic [31:0] a, input logic [31:0] d, input logic rd);
        MemWrite  = mw;
        DataAdr   = a;
        WriteData = d;
        LogRdEn   = rd;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) cyc(2'd0, 32'd0, 32'd0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic start_run(input int n);
        do_reset(n);
        cyc(2'd0, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        logic [65:0] exp_e;
        // 1: pass store right after reset
        do_reset(2);
        chk("rst_rdata", LogRdData, 66'd0);
        chk("rst_empty", 66'(LogEmpty), 66'd1);
        cyc(2'd0, 32'd0, 32'd0, 1'b0);
        cyc(2'd3, 32'd100, 32'd25, 1'b0);
        chk("t1_done", 66'(Done), 66'd1);
        chk("t1_pass", 66'(Pass), 66'd1);
        chk("t1_cause", 66'(FailCause), 66'd0);
        chk("t1_count", 66'(StoreCount), 66'd1);
        exp_e = {2'b11, 32'd100, 32'd25};
        chk("t1_entry", LogRdData, exp_e);

        // 2: allowed store then pass, drain log
        start_run(1);
        cyc(2'd3, 32'd96, 32'd7, 1'b0);
        cyc(2'd3, 32'd100, 32'd25, 1'b0);
        chk("t2_pass", 66'(Pass), 66'd1);
        chk("t2_count", 66'(StoreCount), 66'd2);
        exp_e = {2'b11, 32'd96, 32'd7};
        chk("t2_pop0", LogRdData, exp_e);
        cyc(2'd0, 32'd0, 32'd0, 1'b1);
        exp_e = {2'b11, 32'd100, 32'd25};
        chk("t2_pop1", LogRdData, exp_e);
        cyc(2'd0, 32'd0, 32'd0, 1'b1);
        chk("t2_empty", 66'(LogEmpty), 66'd1);
        cyc(2'd0, 32'd0, 32'd0, 1'b1);

        // 3: failure causes
        start_run(1);
        cyc(2'd3, 32'd104, 32'd1, 1'b0);
        chk("t3_bad", 66'(FailCause), 66'd1);
        chk("t3_nopass", 66'(Pass), 66'd0);
        start_run(1);
        cyc(2'd2, 32'd97, 32'd0, 1'b0);
        chk("t3_misal", 66'(FailCause), 66'd2);
        start_run(1);
        cyc(2'd1, 32'd100, 32'd25, 1'b0);
        chk("t3_byte", 66'(FailCause), 66'd1);

        // 4: timeout with no stores, later stores ignored
        start_run(1);
        for (int i = 0; i < 49; i++) cyc(2'd0, 32'd0, 32'd0, 1'b0);
        chk("t4_notyet", 66'(Done), 66'd0);
        cyc(2'd0, 32'd0, 32'd0, 1'b0);
        chk("t4_done", 66'(Done), 66'd1);
        chk("t4_cause", 66'(FailCause), 66'd3);
        cyc(2'd3, 32'd100, 32'd25, 1'b0);
        chk("t4_ignored", 66'(Pass), 66'd0);
        chk("t4_count", 66'(StoreCount), 66'd0);

        // 5: overflow, ordered drain, then push+pop while full
        start_run(1);
        for (int i = 1; i <= 9; i++) cyc(2'd3, 32'd96, 32'(i * 3), 1'b0);
        chk("t5_full", 66'(LogFull), 66'd1);
        chk("t5_ovf", 66'(LogOverflow), 66'd1);
        chk("t5_count", 66'(StoreCount), 66'd9);
        for (int i = 1; i <= 8; i++) begin
            exp_e = {2'b11, 32'd96, 32'(i * 3)};
            chk("t5_order", LogRdData, exp_e);
            cyc(2'd0, 32'd0, 32'd0, 1'b1);
        end
        chk("t5_drained", 66'(LogEmpty), 66'd1);
        start_run(1);
        for (int i = 1; i <= 8; i++) cyc(2'd3, 32'd96, 32'(i), 1'b0);
        cyc(2'd3, 32'd96, 32'd9, 1'b1);
        chk("t5_pp_full", 66'(LogFull), 66'd1);
        chk("t5_pp_ovf", 66'(LogOverflow), 66'd0);
        exp_e = {2'b11, 32'd96, 32'd2};
        chk("t5_pp_head", LogRdData, exp_e);

        // 6: reset mid-run wipes log and status
        start_run(1);
        for (int i = 0; i < 3; i++) cyc(2'd3, 32'd96, 32'(i), 1'b0);
        do_reset(1);
        chk("t6_empty", 66'(LogEmpty), 66'd1);
        chk("t6_count", 66'(StoreCount), 66'd0);
        chk("t6_done", 66'(Done), 66'd0);
        cyc(2'd0, 32'd0, 32'd0, 1'b0);
        cyc(2'd3, 32'd100, 32'd25, 1'b0);
        chk("t6_rerun", 66'(Pass), 66'd1);

        // Randomized runs; every third run is sparse so timeouts get exercised.
        for (int r = 0; r < 12; r++) begin
            start_run(1);
            for (int c = 0; c < 70; c++) begin
                logic [1:0]  mw;
                logic [31:0] a;
                logic [31:0] d;
                int          k;
                mw = 2'($urandom_range(0, 3));
                if (r % 3 == 2 && $urandom_range(0, 15) != 0) mw = 2'd0;
                k = $urandom_range(0, 19);
                if (r % 3 == 2 || k < 12) a = 32'd96;
                else if (k < 14)          a = 32'd96 + 32'($urandom_range(1, 3));
                else if (k < 17)          a = 32'd100;
                else if (k < 18)          a = 32'd104;
                else                      a = $urandom;
                d = $urandom;
                if ($urandom_range(0, 1) == 1) d = {d[31:8], 8'd25};
                if ($urandom_range(0, 2) == 0) d = 32'd25;
                cyc(mw, a, d, ($urandom_range(0, 3) == 0));
            end
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
